mips_main_ctrl: RTL and testbench
=================================

Name: mips_main_ctrl

Overview:
Multicycle main control FSM for the MIPS datapath. It decodes the instruction opcode and sequences fetch, decode, execute, memory and writeback. It drives every datapath enable, and drives the 3-bit ALUOp consumed by the ALU control decoder. It also takes back that decoder's jr flag to redirect the PC. A mem_ready handshake stretches the memory-access states.

Parameters:
ALUOP_W, 3, ALUOp width (fixed encoding below)
ST_W, 4, state/debug port width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
jr  in  1  Jr flag from ALU control decoder (valid while ALUOp=110 and funct=001000)
mem_ready  in  1  memory access completes this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if branch condition holds
BranchNE  out  1  condition is "not zero" (bne) instead of "zero" (beq)
IorD  out  1  memory address: 0=PC, 1=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
MemtoReg  out  2  writeback source: 00=ALUOut, 01=MDR, 10=PC
RegDst  out  2  destination: 00=rt, 01=rd, 10=$31
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=reg A
ALUSrcB  out  2  00=reg B, 01=4, 10=signext imm, 11=signext imm<<2
ALUOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 use funct, 111 sltu
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=reg A
illegal_op  out  1  sticky: unknown opcode decoded
state_dbg  out  4  current state code

Behaviour:
- rst_n low: state to FETCH asynchronously. All outputs forced to 0 while rst_n low, including illegal_op and state_dbg. This also applies to a reset asserted mid-instruction; no partial write completes.
- Outputs are combinational from the state, plus mem_ready and jr where noted. Signals not listed for a state are 0, except ALUOp=000.
- States and codes:
  - FETCH 0: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00. IRWrite and PCWrite are asserted only when mem_ready=1. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE 1: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target to ALUOut). Next state by opcode:
    - 000000 -> EXEC_R
    - 100011 (lw) and 101011 (sw) -> MEM_ADDR
    - 000100 (beq) and 000101 (bne) -> BRANCH
    - 000010 (j) and 000011 (jal) -> JUMP
    - 001000/001100/001101/001110/001010/001011 (addi/andi/ori/xori/slti/sltiu) -> EXEC_I
    - any other opcode: set illegal_op and go to FETCH. The instruction is a no-op; PC already advanced.
  - EXEC_R 2: ALUSrcA=1, ALUSrcB=00, ALUOp=110. If jr=1: PCWrite=1, PCSource=11, next FETCH, no register write. Otherwise next R_WB.
  - R_WB 3: RegDst=01, MemtoReg=00, RegWrite=1; hold ALUOp=110. Next FETCH.
  - MEM_ADDR 4: ALUSrcA=1, ALUSrcB=10, ALUOp=000. lw -> MEM_RD; sw -> MEM_WR.
  - MEM_RD 5: IorD=1, MemRead=1. Wait here until mem_ready=1, then go to MEM_WB.
  - MEM_WB 6: RegDst=00, MemtoReg=01, RegWrite=1. Next FETCH.
  - MEM_WR 7: IorD=1, MemWrite=1. Wait here until mem_ready=1, then go to FETCH.
  - BRANCH 8: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01, BranchNE=(opcode==000101). Next FETCH.
  - JUMP 9: PCWrite=1, PCSource=10. For jal, also RegDst=10, MemtoReg=10, RegWrite=1. Next FETCH.
  - EXEC_I 10: ALUSrcA=1, ALUSrcB=10. ALUOp by opcode: addi 000, andi 010, ori 011, xori 100, slti 101, sltiu 111. Next I_WB.
  - I_WB 11: RegDst=00, MemtoReg=00, RegWrite=1; hold EXEC_I's ALUOp. Next FETCH.
  - Codes 12-15 are unreachable. If ever entered, go to FETCH with all outputs 0.
- illegal_op is sticky until reset.
- MemRead and MemWrite are never both 1. RegWrite and PCWrite are both 1 only in JUMP for jal.
- Cycle counts with mem_ready tied to 1:
  - R-type: 4 cycles; jr: 3
  - lw: 5; sw: 4
  - beq/bne: 3
  - j/jal: 3
  - I-type ALU: 4
  - Each mem_ready=0 cycle adds one cycle.

Test Plan:
1. Reset mid-MEM_WR (rst_n low while MemWrite=1) -> all outputs 0 at once. After release, state_dbg=0, MemRead=1, ALUSrcB=01.
2. opcode=100011, mem_ready=1 -> states 0,1,4,5,6,0. MEM_WB has RegWrite=1, MemtoReg=01, RegDst=00. With mem_ready=0 for 2 cycles in MEM_RD, total is 7 cycles.
3. opcode=000000 with jr=0 -> EXEC_R ALUOp=110, then R_WB RegDst=01 RegWrite=1. With jr=1 -> PCWrite=1, PCSource=11, no RegWrite, back to FETCH.
4. opcode=000101 -> BRANCH: ALUOp=001, PCWriteCond=1, BranchNE=1, PCSource=01. With opcode=000100, BranchNE=0.
5. opcode=001110 (xori) -> EXEC_I ALUOp=100, ALUSrcB=10, then I_WB RegWrite=1. opcode=001011 (sltiu) -> ALUOp=111.
6. opcode=000011 (jal) -> JUMP: PCWrite=1, PCSource=10, RegDst=10, MemtoReg=10, RegWrite=1. opcode=111111 -> illegal_op=1, returns to FETCH with no writes, and illegal_op stays 1 until rst_n low.

Source files
------------

// File: rtl/mips_main_ctrl.sv
// Purpose: multicycle MIPS main control FSM; sequences fetch/decode/execute/memory/writeback
//          and drives every datapath enable plus the 3-bit ALUOp for the ALU control decoder.
// Ports:   clk, rst_n (async active-low); opcode, jr, mem_ready in; datapath controls,
//          sticky illegal_op and state_dbg out. Controls are combinational from state,
//          opcode, mem_ready and jr; mem_ready stretches FETCH, MEM_RD and MEM_WR.
module mips_main_ctrl #(
   parameter int ALUOP_W = 3,
   parameter int ST_W    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic               jr,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               BranchNE,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic [1:0]         MemtoReg,
   output logic [1:0]         RegDst,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [1:0]         PCSource,
   output logic               illegal_op,
   output logic [ST_W-1:0]    state_dbg
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_R   = 4'd2,
      R_WB     = 4'd3,
      MEM_ADDR = 4'd4,
      MEM_RD   = 4'd5,
      MEM_WB   = 4'd6,
      MEM_WR   = 4'd7,
      BRANCH   = 4'd8,
      JUMP     = 4'd9,
      EXEC_I   = 4'd10,
      I_WB     = 4'd11
   } state_t;

   state_t state_q, state_d;
   logic   illegal_op_q, illegal_op_d;
   logic [2:0] alu_op;
   logic [2:0] imm_alu_op;

   // I-type ALU operation; opcode stays valid through I_WB so the op is simply re-derived there.
   always_comb begin
      imm_alu_op = 3'b000;
      case (opcode)
         OP_ANDI:  imm_alu_op = 3'b010;
         OP_ORI:   imm_alu_op = 3'b011;
         OP_XORI:  imm_alu_op = 3'b100;
         OP_SLTI:  imm_alu_op = 3'b101;
         OP_SLTIU: imm_alu_op = 3'b111;
         default:  imm_alu_op = 3'b000;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      illegal_op_d = illegal_op_q;
      PCWrite      = 1'b0;
      PCWriteCond  = 1'b0;
      BranchNE     = 1'b0;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      MemtoReg     = 2'b00;
      RegDst       = 2'b00;
      RegWrite     = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 2'b00;
      alu_op       = 3'b000;
      PCSource     = 2'b00;
      // Outputs are held at zero for the whole time reset is low, even though the
      // state register already reads FETCH, so no partial access leaks out.
      if (rst_n) begin
         case (state_q)
            FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
               if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
               ALUSrcB = 2'b11;
               case (opcode)
                  OP_RTYPE:                state_d = EXEC_R;
                  OP_LW, OP_SW:            state_d = MEM_ADDR;
                  OP_BEQ, OP_BNE:          state_d = BRANCH;
                  OP_J, OP_JAL:            state_d = JUMP;
                  OP_ADDI, OP_ANDI, OP_ORI,
                  OP_XORI, OP_SLTI, OP_SLTIU: state_d = EXEC_I;
                  default: begin
                     // Unknown opcode retires as a no-op; the PC was already advanced in FETCH.
                     illegal_op_d = 1'b1;
                     state_d      = FETCH;
                  end
               endcase
            end
            EXEC_R: begin
               ALUSrcA = 1'b1;
               alu_op  = 3'b110;
               if (jr) begin
                  PCWrite  = 1'b1;
                  PCSource = 2'b11;
                  state_d  = FETCH;
               end else begin
                  state_d = R_WB;
               end
            end
            R_WB: begin
               RegDst   = 2'b01;
               RegWrite = 1'b1;
               alu_op   = 3'b110;
               state_d  = FETCH;
            end
            MEM_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
               IorD    = 1'b1;
               MemRead = 1'b1;
               if (mem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
               MemtoReg = 2'b01;
               RegWrite = 1'b1;
               state_d  = FETCH;
            end
            MEM_WR: begin
               IorD     = 1'b1;
               MemWrite = 1'b1;
               if (mem_ready) state_d = FETCH;
            end
            BRANCH: begin
               ALUSrcA     = 1'b1;
               alu_op      = 3'b001;
               PCWriteCond = 1'b1;
               PCSource    = 2'b01;
               BranchNE    = (opcode == OP_BNE);
               state_d     = FETCH;
            end
            JUMP: begin
               PCWrite  = 1'b1;
               PCSource = 2'b10;
               if (opcode == OP_JAL) begin
                  RegDst   = 2'b10;
                  MemtoReg = 2'b10;
                  RegWrite = 1'b1;
               end
               state_d = FETCH;
            end
            EXEC_I: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               alu_op  = imm_alu_op;
               state_d = I_WB;
            end
            I_WB: begin
               RegWrite = 1'b1;
               alu_op   = imm_alu_op;
               state_d  = FETCH;
            end
            // Codes 12-15: all outputs stay at their zero defaults; recover to FETCH.
            default: state_d = FETCH;
         endcase
      end
   end

   assign ALUOp      = ALUOP_W'(alu_op);
   assign illegal_op = rst_n & illegal_op_q;
   assign state_dbg  = rst_n ? ST_W'(state_q) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FETCH;
         illegal_op_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         illegal_op_q <= illegal_op_d;
      end
   end

endmodule

// File: tb/tb_mips_main_ctrl.sv
module tb_mips_main_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       jr;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
   logic [1:0] MemtoReg, RegDst, ALUSrcB, PCSource;
   logic       RegWrite, ALUSrcA, illegal_op;
   logic [2:0] ALUOp;
   logic [3:0] state_dbg;

   int checks = 0;
   int errors = 0;

   mips_main_ctrl #(.ALUOP_W(3), .ST_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .jr(jr), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
      .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .PCSource(PCSource), .illegal_op(illegal_op), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   logic [24:0] all_out;
   assign all_out = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                     illegal_op, state_dbg};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and check the state entered.
   task automatic go(input logic [3:0] exp_state);
      @(posedge clk);
      #1;
      chk("state", 32'(state_dbg), 32'(exp_state));
   endtask

   initial begin
      rst_n = 1'b0; opcode = 6'b0; jr = 1'b0; mem_ready = 1'b1;
      #2;
      chk("reset_all_zero", 32'(all_out), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("rel_state", 32'(state_dbg), 32'd0);
      chk("rel_memread", 32'(MemRead), 32'd1);
      chk("rel_alusrcb", 32'(ALUSrcB), 32'd1);
      chk("fetch_irwrite", 32'(IRWrite), 32'd1);
      chk("fetch_pcwrite", 32'(PCWrite), 32'd1);
      mem_ready = 1'b0;
      #1;
      chk("fetch_stall_irwrite", 32'(IRWrite), 32'd0);
      chk("fetch_stall_pcwrite", 32'(PCWrite), 32'd0);
      go(4'd0);
      mem_ready = 1'b1;

      // sw, then reset asserted while MemWrite is high
      opcode = 6'b101011;
      go(4'd1); go(4'd4); go(4'd7);
      mem_ready = 1'b0;
      #1;
      chk("memwr_write", 32'(MemWrite), 32'd1);
      chk("memwr_iord", 32'(IorD), 32'd1);
      chk("memwr_no_read", 32'(MemRead), 32'd0);
      go(4'd7);
      rst_n = 1'b0;
      #1;
      chk("midreset_all_zero", 32'(all_out), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; mem_ready = 1'b1;
      #1;
      chk("rst2_state", 32'(state_dbg), 32'd0);
      chk("rst2_memread", 32'(MemRead), 32'd1);
      chk("rst2_alusrcb", 32'(ALUSrcB), 32'd1);

      // lw, no stalls: 0,1,4,5,6,0
      opcode = 6'b100011;
      go(4'd1);
      chk("dec_alusrcb", 32'(ALUSrcB), 32'd3);
      go(4'd4);
      chk("memaddr_alusrcb", 32'(ALUSrcB), 32'd2);
      go(4'd5);
      chk("memrd_read", 32'(MemRead), 32'd1);
      go(4'd6);
      chk("memwb_regwrite", 32'(RegWrite), 32'd1);
      chk("memwb_memtoreg", 32'(MemtoReg), 32'd1);
      chk("memwb_regdst", 32'(RegDst), 32'd0);
      go(4'd0);

      // lw with two stall cycles in MEM_RD: 7 cycles total
      go(4'd1); go(4'd4); go(4'd5);
      mem_ready = 1'b0;
      go(4'd5); go(4'd5);
      mem_ready = 1'b1;
      go(4'd6); go(4'd0);

      // R-type, jr=0
      opcode = 6'b000000; jr = 1'b0;
      go(4'd1); go(4'd2);
      chk("execr_aluop", 32'(ALUOp), 32'd6);
      chk("execr_alusrca", 32'(ALUSrcA), 32'd1);
      chk("execr_alusrcb", 32'(ALUSrcB), 32'd0);
      go(4'd3);
      chk("rwb_regdst", 32'(RegDst), 32'd1);
      chk("rwb_regwrite", 32'(RegWrite), 32'd1);
      chk("rwb_aluop", 32'(ALUOp), 32'd6);
      go(4'd0);

      // jr
      go(4'd1);
      jr = 1'b1;
      go(4'd2);
      chk("jr_pcwrite", 32'(PCWrite), 32'd1);
      chk("jr_pcsource", 32'(PCSource), 32'd3);
      chk("jr_regwrite", 32'(RegWrite), 32'd0);
      go(4'd0);
      jr = 1'b0;

      // bne then beq
      opcode = 6'b000101;
      go(4'd1); go(4'd8);
      chk("bne_aluop", 32'(ALUOp), 32'd1);
      chk("bne_pcwritecond", 32'(PCWriteCond), 32'd1);
      chk("bne_branchne", 32'(BranchNE), 32'd1);
      chk("bne_pcsource", 32'(PCSource), 32'd1);
      go(4'd0);
      opcode = 6'b000100;
      go(4'd1); go(4'd8);
      chk("beq_branchne", 32'(BranchNE), 32'd0);
      go(4'd0);

      // xori then sltiu
      opcode = 6'b001110;
      go(4'd1); go(4'd10);
      chk("xori_aluop", 32'(ALUOp), 32'd4);
      chk("xori_alusrcb", 32'(ALUSrcB), 32'd2);
      go(4'd11);
      chk("xori_wb_regwrite", 32'(RegWrite), 32'd1);
      chk("xori_wb_aluop", 32'(ALUOp), 32'd4);
      go(4'd0);
      opcode = 6'b001011;
      go(4'd1); go(4'd10);
      chk("sltiu_aluop", 32'(ALUOp), 32'd7);
      go(4'd11); go(4'd0);

      // jal then j
      opcode = 6'b000011;
      go(4'd1); go(4'd9);
      chk("jal_pcwrite", 32'(PCWrite), 32'd1);
      chk("jal_pcsource", 32'(PCSource), 32'd2);
      chk("jal_regdst", 32'(RegDst), 32'd2);
      chk("jal_memtoreg", 32'(MemtoReg), 32'd2);
      chk("jal_regwrite", 32'(RegWrite), 32'd1);
      go(4'd0);
      opcode = 6'b000010;
      go(4'd1); go(4'd9);
      chk("j_regwrite", 32'(RegWrite), 32'd0);
      go(4'd0);

      // illegal opcode
      chk("illegal_before", 32'(illegal_op), 32'd0);
      opcode = 6'b111111;
      go(4'd1);
      chk("illegal_dec_regwrite", 32'(RegWrite), 32'd0);
      go(4'd0);
      chk("illegal_set", 32'(illegal_op), 32'd1);
      opcode = 6'b000010;
      go(4'd1); go(4'd9); go(4'd0);
      chk("illegal_sticky", 32'(illegal_op), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("illegal_cleared", 32'(illegal_op), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("illegal_after_rst", 32'(illegal_op), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
